// File: rtl/traffic_light_monitor.sv
// Passive checker for the RED/GREEN/YELLOW lights bus.
// Optional err_clr port: define TLM_ERR_CLEAR_EN.
module traffic_light_monitor #(
  parameter int RED_CYC    = 8,
  parameter int GREEN_CYC  = 6,
  parameter int YELLOW_CYC = 2,
  parameter int CNT_W      = 8,
  parameter int CYC_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
`ifdef TLM_ERR_CLEAR_EN
  input  logic             err_clr,
`endif
  input  logic [2:0]       lights,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] phase_cnt,
  output logic [CYC_W-1:0] cycle_cnt,
  output logic             err_illegal,
  output logic             err_seq,
  output logic             err_timing,
  output logic             err_any
);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    RED    = 2'd1,
    GREEN  = 2'd2,
    YELLOW = 2'd3
  } phase_t;

  localparam logic [2:0] C_RED = 3'b100;
  localparam logic [2:0] C_YEL = 3'b010;
  localparam logic [2:0] C_GRN = 3'b001;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] RED_N   = CNT_W'(RED_CYC);
  localparam logic [CNT_W-1:0] GRN_N   = CNT_W'(GREEN_CYC);
  localparam logic [CNT_W-1:0] YEL_N   = CNT_W'(YELLOW_CYC);

  phase_t           st, st_n, code_ph, succ;
  logic [2:0]       lights_d;
  logic [CNT_W-1:0] cnt_n, req;
  logic [CYC_W-1:0] cyc_n;
  logic             ill_n, seq_n, tim_n;
  logic             primed;
  logic             changed;
  logic             clr;

`ifdef TLM_ERR_CLEAR_EN
  assign clr = err_clr;
`else
  assign clr = 1'b0;
`endif

  assign phase   = st;
  assign changed = (lights != lights_d);

  // Decode the bus; anything not one-hot maps to SYNC.
  always_comb begin
    code_ph = SYNC;
    unique case (1'b1)
      (lights == C_RED): code_ph = RED;
      (lights == C_GRN): code_ph = GREEN;
      (lights == C_YEL): code_ph = YELLOW;
      default:           code_ph = SYNC;
    endcase
  end

  // Required length and legal successor of the current phase.
  always_comb begin
    req  = CNT_MAX;
    succ = SYNC;
    unique case (st)
      RED:    begin req = RED_N; succ = GREEN;  end
      GREEN:  begin req = GRN_N; succ = YELLOW; end
      YELLOW: begin req = YEL_N; succ = RED;    end
      default: begin req = CNT_MAX; succ = SYNC; end
    endcase
  end

  // Next phase, counters and flags; clear loses to a new error.
  always_comb begin
    st_n  = st;
    cyc_n = cycle_cnt;
    ill_n = err_illegal & ~clr;
    seq_n = err_seq & ~clr;
    tim_n = err_timing & ~clr;
    if (changed)
      cnt_n = CNT_W'(1);
    else if (phase_cnt == CNT_MAX)
      cnt_n = phase_cnt;
    else
      cnt_n = phase_cnt + CNT_W'(1);
    if (code_ph == SYNC)
      ill_n = 1'b1;
    // First edge after reset only captures the bus: that phase is partial.
    if (!primed) begin
      st_n = SYNC;
    end else if (changed) begin
      if (st == SYNC) begin
        st_n = code_ph;
      end else begin
        if (phase_cnt != req)
          tim_n = 1'b1;
        st_n = code_ph;
        if (code_ph != SYNC) begin
          if (code_ph != succ)
            seq_n = 1'b1;
          else if (st == YELLOW)
            cyc_n = cycle_cnt + CYC_W'(1);
        end
      end
    end
  end

  // State, counter and sticky-flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= SYNC;
      lights_d    <= 3'b000;
      primed      <= 1'b0;
      phase_cnt   <= '0;
      cycle_cnt   <= '0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      err_timing  <= 1'b0;
      err_any     <= 1'b0;
    end else begin
      st          <= st_n;
      lights_d    <= lights;
      primed      <= 1'b1;
      phase_cnt   <= cnt_n;
      cycle_cnt   <= cyc_n;
      err_illegal <= ill_n;
      err_seq     <= seq_n;
      err_timing  <= tim_n;
      err_any     <= ill_n | seq_n | tim_n;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor.
// Covers err_clr when TLM_ERR_CLEAR_EN is defined.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  lights;
  logic [1:0]  phase;
  logic [7:0]  phase_cnt;
  logic [15:0] cycle_cnt;
  logic        err_illegal, err_seq, err_timing, err_any;
`ifdef TLM_ERR_CLEAR_EN
  logic        err_clr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk         (clk),
    .reset       (reset),
`ifdef TLM_ERR_CLEAR_EN
    .err_clr     (err_clr),
`endif
    .lights      (lights),
    .phase       (phase),
    .phase_cnt   (phase_cnt),
    .cycle_cnt   (cycle_cnt),
    .err_illegal (err_illegal),
    .err_seq     (err_seq),
    .err_timing  (err_timing),
    .err_any     (err_any)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [2:0] code, input int n);
    lights = code;
    repeat (n) tick();
  endtask

  function automatic logic [3:0] errs();
    return {err_illegal, err_seq, err_timing, err_any};
  endfunction

  initial begin
    reset  = 1'b0;
    lights = R;
`ifdef TLM_ERR_CLEAR_EN
    err_clr = 1'b0;
`endif
    #3;
    chk("rst_phase", 32'(phase), 0);
    chk("rst_cnt",   32'(phase_cnt), 0);
    chk("rst_cyc",   32'(cycle_cnt), 0);
    chk("rst_err",   32'(errs()), 0);
    tick();
    reset = 1'b1;

    // legal sequence, first RED partial
    hold(R, 5);
    chk("sync_phase", 32'(phase), 0);
    chk("sync_cnt",   32'(phase_cnt), 5);
    hold(G, 6);
    chk("grn_phase",  32'(phase), 2);
    chk("grn_cnt6",   32'(phase_cnt), 6);
    hold(Y, 1);
    chk("yel_phase",  32'(phase), 3);
    chk("yel_cnt1",   32'(phase_cnt), 1);
    hold(Y, 1);
    hold(R, 1);
    chk("red_phase",  32'(phase), 1);
    chk("cyc1",       32'(cycle_cnt), 1);
    hold(R, 7);
    hold(G, 6);
    hold(Y, 2);
    hold(R, 1);
    chk("cyc2",       32'(cycle_cnt), 2);
    chk("legal_err",  32'(errs()), 0);

    // short GREEN
    hold(R, 7);
    hold(G, 5);
    hold(Y, 1);
    chk("dur_err",    32'(errs()), 4'b0011);
    chk("dur_phase",  32'(phase), 3);

    // async reset mid-YELLOW with a flag set
    reset = 1'b0;
    #1;
    chk("mid_phase",  32'(phase), 0);
    chk("mid_cnt",    32'(phase_cnt), 0);
    chk("mid_cyc",    32'(cycle_cnt), 0);
    chk("mid_err",    32'(errs()), 0);
    repeat (2) tick();
    reset = 1'b1;
    hold(Y, 3);
    chk("post_sync",  32'(phase), 0);
    hold(R, 1);
    chk("post_phase", 32'(phase), 1);
    chk("post_err",   32'(errs()), 0);
    chk("post_cyc",   32'(cycle_cnt), 0);

    // RED 8 then YELLOW out of order
    hold(R, 7);
    hold(Y, 1);
    chk("ord_err",    32'(errs()), 4'b0101);
    chk("ord_phase",  32'(phase), 3);
    chk("ord_cyc",    32'(cycle_cnt), 0);

    // illegal code inside a tracked GREEN
    reset = 1'b0;
    lights = R;
    repeat (2) tick();
    reset = 1'b1;
    hold(R, 3);
    hold(G, 3);
    hold(3'b110, 1);
    chk("ill_err",    32'(errs()), 4'b1011);
    chk("ill_phase",  32'(phase), 0);
    hold(Y, 2);
    chk("rsy_phase",  32'(phase), 3);
    hold(R, 1);
    chk("rsy_red",    32'(phase), 1);
    chk("rsy_cyc",    32'(cycle_cnt), 1);
    chk("rsy_err",    32'(errs()), 4'b1011);

    // phase counter saturation
    hold(R, 259);
    chk("sat_cnt",    32'(phase_cnt), 255);

`ifdef TLM_ERR_CLEAR_EN
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err",    32'(errs()), 0);
    chk("clr_phase",  32'(phase), 1);
    chk("clr_cyc",    32'(cycle_cnt), 1);
    err_clr = 1'b1;
    hold(G, 1);
    err_clr = 1'b0;
    chk("clr_win",    32'(errs()), 4'b0011);
    chk("clr_wphase", 32'(phase), 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
